// File: rtl/readout_pkg.sv
// Shared definitions for the channel readout arbiter: control-word layout,
// block-size limits and the FSM state type.
package readout_pkg;

  localparam int CW_FLAG   = 15;
  localparam int CW_CH_HI  = 14;
  localparam int CW_CH_LO  = 9;
  localparam int CW_LEN_HI = 8;
  localparam int CW_LEN_LO = 0;

  localparam int MAXBLK  = 512;
  localparam int LEN_W   = 9;
  localparam int DEF_TMO = 255;

  typedef enum logic {
    ST_SCAN,
    ST_BODY
  } arb_state_e;

  function automatic logic [LEN_W-1:0] cw_len(input logic [15:0] w);
    return w[CW_LEN_HI:CW_LEN_LO];
  endfunction

endpackage

// File: rtl/rr_ptr.sv
// Round-robin channel pointer: steps on skip or advance unless held,
// wrapping from NCH-1 back to 0 (NCH need not be a power of two).
module rr_ptr #(
  parameter int NCH = 16,
  parameter int PW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          skip_i,
  input  logic          adv_i,
  input  logic          hold_i,
  output logic [PW-1:0] ptr_o
);

  localparam logic [PW-1:0] LAST = PW'(NCH - 1);

  logic [PW-1:0] ptr_q;
  logic          step;

  assign step  = (skip_i | adv_i) & ~hold_i;
  assign ptr_o = ptr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (step) begin
      ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/chan_readout_arb.sv
// Round-robin readout arbiter: grants one channel at a time and forwards
// whole CW-headed blocks, unchanged, to a single registered output stream.
module chan_readout_arb
  import readout_pkg::*;
#(
  parameter int NCH = 16,
  parameter int TMO = DEF_TMO
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NCH-1:0]      give,
  input  logic [NCH-1:0]      have,
  input  logic [16*NCH-1:0]   din,
  input  logic [NCH-1:0]      cmask,
  input  logic                stop,
  output logic [15:0]         dout,
  output logic                dvld,
  output logic                dsof,
  output logic                deof,
  output logic                err,
  output logic [15:0]         errcnt
);

  localparam int            PW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [7:0]    TMO_LIM = 8'(TMO);

  arb_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [15:0]      dout_q, dout_d;
  logic             dvld_q, dvld_d;
  logic             dsof_q, dsof_d;
  logic             deof_q, deof_d;
  logic             err_q, err_d;
  logic [15:0]      errcnt_q;

  logic [PW-1:0]    ptr;
  logic             adv, skip, hold;
  logic [NCH-1:0]   give_raw;
  logic [15:0]      word;
  logic             have_sel;

  assign word     = din[16*ptr +: 16];
  assign have_sel = have[ptr];
  assign hold     = (state_q == ST_SCAN) && stop;

  rr_ptr #(.NCH(NCH), .PW(PW)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .skip_i (skip),
    .adv_i  (adv),
    .hold_i (hold),
    .ptr_o  (ptr)
  );

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    dout_d   = dout_q;
    dvld_d   = 1'b0;
    dsof_d   = 1'b0;
    deof_d   = 1'b0;
    err_d    = 1'b0;
    adv      = 1'b0;
    skip     = 1'b0;
    give_raw = '0;

    unique case (state_q)
      ST_SCAN: begin
        if (stop) begin
          // Downstream lacks room for a full block: park on this channel.
        end else if (cmask[ptr]) begin
          skip = 1'b1;
        end else begin
          give_raw[ptr] = 1'b1;
          if (!have_sel) begin
            adv = 1'b1;
          end else if (word[CW_FLAG]) begin
            dout_d = word;
            dvld_d = 1'b1;
            dsof_d = 1'b1;
            if (cw_len(word) == '0) begin
              deof_d = 1'b1;
              adv    = 1'b1;
            end else begin
              cnt_d   = cw_len(word);
              tmo_d   = '0;
              state_d = ST_BODY;
            end
          end else begin
            // Not a CW: drop the word and move on to resynchronise.
            err_d = 1'b1;
            adv   = 1'b1;
          end
        end
      end

      ST_BODY: begin
        if (tmo_q == TMO_LIM) begin
          err_d   = 1'b1;
          adv     = 1'b1;
          state_d = ST_SCAN;
        end else begin
          give_raw[ptr] = 1'b1;
          if (have_sel) begin
            dout_d = word;
            dvld_d = 1'b1;
            cnt_d  = cnt_q - 1'b1;
            tmo_d  = '0;
            if (cnt_q == LEN_W'(1)) begin
              deof_d  = 1'b1;
              adv     = 1'b1;
              state_d = ST_SCAN;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SCAN;
      cnt_q    <= '0;
      tmo_q    <= '0;
      dout_q   <= '0;
      dvld_q   <= 1'b0;
      dsof_q   <= 1'b0;
      deof_q   <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      dsof_q  <= dsof_d;
      deof_q  <= deof_d;
      err_q   <= err_d;
      if (err_d && (errcnt_q != 16'hFFFF)) begin
        errcnt_q <= errcnt_q + 1'b1;
      end
    end
  end

  // The grant is combinational, so it is gated by reset to drop at once.
  assign give   = rst ? '0 : give_raw;
  assign dout   = dout_q;
  assign dvld   = dvld_q;
  assign dsof   = dsof_q;
  assign deof   = deof_q;
  assign err    = err_q;
  assign errcnt = errcnt_q;

endmodule

// File: doc/chan_readout_arb.md
Name: chan_readout_arb

Overview:
- Round-robin readout arbiter for the per-channel processing blocks in the channel FPGA.
- Drives each channel's give request and accepts its have acknowledge and 16-bit data.
- Forwards whole blocks, unchanged and never interleaved, to the single downstream stream toward the GTP sender.
- The block length comes from the control word (CW) at the head of each block; CW format is 1CCC CCCL LLLL LLLL.

Parameters:
- NCH, 16, number of channel processors served.
- TMO, 255, maximum idle clk cycles inside a block before abort (8-bit counter).

Ports:
- clk  in  1  125 MHz system clock; all logic in this domain.
- rst  in  1  asynchronous, active-high reset.
- give  out  NCH  one-hot request to channel i.
- have  in  NCH  channel i acknowledge, combinational with give[i]; a word is consumed in every cycle with give[i]&have[i].
- din  in  16*NCH  channel i data on bits [16i+15:16i]; valid when have[i].
- cmask  in  NCH  1 = skip channel (give never asserted).
- stop  in  1  downstream cannot take a 512-word block; sampled only before starting a block.
- dout  out  16  forwarded word, registered.
- dvld  out  1  dout valid.
- dsof  out  1  dout is a CW.
- deof  out  1  dout is the last word of a block.
- err  out  1  one-clk pulse: bad CW or timeout abort.
- errcnt  out  16  saturating error counter.

Behaviour:
- Reset values: give=0, dout=0, dvld=0, dsof=0, deof=0, err=0, errcnt=0, ptr=0, state=SCAN.
- Latency: the din word taken in cycle n appears on dout with dvld=1 in cycle n+1.
- SCAN (ptr selects the channel):
  - If cmask[ptr] or stop: give=0; ptr advances next cycle, except on stop, where ptr holds.
  - Otherwise give[ptr]=1.
  - have[ptr]=0: ptr <= ptr+1 (mod NCH); 1 cycle per empty channel.
  - have[ptr]=1 and din[15]=1: forward CW with dsof=1; cnt <= din[8:0].
    - cnt=0: deof=1 on the CW; ptr++; stay in SCAN.
    - cnt≠0: go to BODY with give held.
  - have[ptr]=1 and din[15]=0: word is consumed and dropped; err pulse; errcnt++; ptr++; stay in SCAN (resync).
- BODY:
  - give[ptr]=1 continuously.
  - Each have cycle: forward word, cnt--, tmo cleared.
  - Word with cnt==1: deof=1; give drops the next cycle; ptr++; go to SCAN.
  - No-have cycles: tmo++. At tmo==TMO: give=0, err pulse, errcnt++, ptr++, go to SCAN. No deof is emitted; downstream discards an unterminated block at the next dsof.
- give never asserts to more than one channel. Only din of the granted channel is sampled.
- stop asserted mid-block is ignored; the downstream guarantees ≥512 words of headroom when it releases stop.
- Block length in words = CW[8:0]+1. Max 512, so cnt is 9 bits.
- ptr wraps NCH-1 -> 0. NCH need not be a power of two.
- errcnt saturates at 0xFFFF.
- Async rst mid-block: all outputs and give clear immediately. The partial block is lost, so the downstream must be reset together.
- cmask change mid-block: takes effect only at the next SCAN visit.
- Fairness: at most one block per channel per round-robin pass.

Decomposition:
- Shared package (readout_pkg):
  - CW field positions: CW_FLAG=15, CW_CH=14:9, CW_LEN=8:0.
  - MAXBLK=512.
  - Default TMO.
- One sub-module, rr_ptr: round-robin pointer with skip/advance/hold inputs and mod-NCH wrap. Muxing and the FSM stay in chan_readout_arb.

Test Plan:
- Channel 3 alone has CW 0x8605 plus 5 data words, all others empty, stop=0 -> dout 0x8605 (dsof), then 5 words, deof on the 5th; give[3] high for exactly 6 have cycles; no err.
- Channels 0, 1 and 2 each hold 2 blocks of L=2 -> order ch0, ch1, ch2, ch0, ch1, ch2; 18 dvld words; no block interleaving.
- Channel 5 CW 0x8A00 (L=0) -> single word with dsof=deof=1; ptr moves to 6.
- Channel 2 first word 0x1234 -> word dropped, err pulse, errcnt=1, no dvld; the next channel is served normally.
- Channel 4 CW L=10 with have stalling after 3 words for 300 cycles -> err after 255 idle cycles, give[4] drops, errcnt=1, no deof.
- stop=1 with data pending -> no give for 100 cycles; then stop=0 -> block starts within 1 cycle. Also: rst asserted mid-block -> give=0 and dvld=0 immediately.
